lag_pl_fc_in: RTL and testbench
===============================

# lag_pl_fc_in

Receive-side half of the physical-channel credit flow-control link. It accepts flits tagged with a physical-lane (PL) valid vector and stores each flit in a per-PL FIFO of `buf_depth` entries. It presents each FIFO head to the downstream router logic. For every flit the router dequeues, it returns one credit pulse to the upstream credit counter. It sits at a router input port, facing the upstream output-port credit counter across the link.

## Interface
Parameters:
- `num_pls`, 4, number of physical lanes.
- `buf_depth`, 4, entries per PL FIFO; must equal the upstream `init_credits`.
- `flit_width`, 32, flit payload width in bits.
- `counter_bits`, `clogb2(buf_depth+1)`, occupancy counter width (holds 0..`buf_depth`).
- `ptr_bits`, `clogb2(buf_depth)` (minimum 1), FIFO pointer width.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flit_in` in `flit_width`: incoming flit payload.
- `flit_in_valid` in `num_pls`: bit i set means `flit_in` belongs to PL i; at most one bit set.
- `pl_deq` in `num_pls`: bit i pops the head of PL i this cycle.
- `pl_head_data` out `num_pls`×`flit_width`: head flit per PL; 0 when `pl_head_valid[i]`=0.
- `pl_head_valid` out `num_pls`: PL i FIFO non-empty.
- `pl_occupancy` out `num_pls`×`counter_bits`: entries held per PL.
- `credits_out` out `num_pls`: one-cycle credit pulse per freed entry (drives `chan_cntrl_t.credits`).
- `overflow_err` out 1: sticky; set on a write to a full PL.
- `underflow_err` out 1: sticky; set on a dequeue of an empty PL.
- `proto_err` out 1: sticky; set when `flit_in_valid` has more than one bit set.

## Operation
- Per PL i there is a circular buffer with `wr_ptr`, `rd_ptr` and occupancy `occ`. Pointers advance modulo `buf_depth`: they wrap from `buf_depth-1` to 0. `buf_depth` need not be a power of two.
- **Enqueue:**
  - Condition: `flit_in_valid[i]`=1, exactly one valid bit set, and `occ[i]`<`buf_depth`.
  - Action: store `flit_in` at `wr_ptr[i]`, advance `wr_ptr[i]`.
- **Dequeue:**
  - Condition: `pl_deq[i]`=1 and `occ[i]`>0, evaluated on the pre-edge `occ`.
  - Action: advance `rd_ptr[i]`.
- **Occupancy update:**
  - enqueue only: `occ`+1.
  - dequeue only: `occ`−1.
  - both: unchanged.
  - neither: unchanged.
- **Full PL:**
  - A write to a full PL is dropped and sets `overflow_err`, even if the same PL dequeues in that cycle.
  - This cannot occur under correct upstream credit accounting.
- **Empty PL:**
  - A dequeue of an empty PL is ignored, returns no credit, and sets `underflow_err`.
  - There is no enqueue-to-dequeue bypass: a simultaneous write and dequeue on an empty PL stores the flit and flags underflow.
- **Multi-hot valid:** if more than one `flit_in_valid` bit is set, all writes that cycle are dropped and `proto_err` is set. Dequeues still proceed.
- **Credit return:** each successful dequeue of PL i causes `credits_out[i]`=1 for exactly one cycle. Dequeues on different PLs in the same cycle produce simultaneous pulses.
- **Error flags:** the three error flags clear only on `rst`.

## Timing
- **Reset values:** on a `rst`-high edge:
  - all `occ`, pointers, `pl_head_valid`, `pl_occupancy`, `credits_out` and error flags become 0;
  - `pl_head_data` reads 0;
  - FIFO storage is not reset.
- **Reset mid-operation:** all stored flits are discarded and in-flight credit pulses are cancelled. `rst` has priority over every other input that cycle.
- **Write-to-head latency:** a flit written at edge t appears on `pl_head_data`/`pl_head_valid` after edge t. It can be dequeued in cycle t+1.
- **Dequeue-to-next-head:** after a dequeue at edge t, the next entry (or `pl_head_valid`=0) is visible after edge t.
- **Credit latency:** a dequeue sampled at edge t makes `credits_out[i]` registered high for the cycle following edge t.
- **Round trip:** with the upstream optimized counter, a freed slot is reusable upstream no earlier than 2 cycles after the dequeue. Full throughput on one PL therefore requires `buf_depth` ≥ 4.
- **Occupancy output:** `pl_occupancy` is registered and reflects state after the last edge.
- **Error flags:** each flag rises after the offending edge and holds until reset.

## Test plan
- **Reset and single flit:** after reset, write 0xA5 on PL 2.
  - Cycle after: `pl_head_valid`=4'b0100, `pl_head_data[2]`=0xA5, `pl_occupancy[2]`=1.
  - Dequeue: `credits_out`=4'b0100 for one cycle, then `occ`=0.
- **Fill and wrap:**
  - Write 4 flits 1..4 to PL 0: `occ`=4.
  - Then 6 alternating dequeue/enqueue cycles writing 5..7.
  - Required: heads read 1,2,3,4,5,6,7 in order across the pointer wrap; exactly 7 credit pulses on dequeue.
- **Simultaneous events:**
  - PL 1 holds 2 flits; enqueue to PL 1 and dequeue PL 1 in the same cycle: `occ` stays 2 and one credit is returned.
  - Dequeue PL 0 and PL 3 together: `credits_out`=4'b1001.
- **Overflow and underflow:**
  - Write a 5th flit to full PL 0 with `pl_deq[0]`=1: flit dropped, `overflow_err`=1, `occ`=3, one credit.
  - Dequeue empty PL 3: no credit, `underflow_err`=1.
- **Protocol error and reset:**
  - `flit_in_valid`=4'b0011: nothing stored, `proto_err`=1.
  - Assert `rst` for one cycle with flits queued and a credit pending: all outputs 0 on the next cycle and no credit pulse.

Source files
------------

// File: rtl/lag_pl_fc_in.sv
// Receive side of the physical-lane credit link: per-PL flit FIFOs with registered
// heads, occupancy, one-cycle credit return per dequeue, and sticky error flags.
module lag_pl_fc_in #(
    parameter int unsigned num_pls      = 4,
    parameter int unsigned buf_depth    = 4,
    parameter int unsigned flit_width   = 32,
    parameter int unsigned counter_bits = $clog2(buf_depth + 1),
    parameter int unsigned ptr_bits     = (buf_depth > 1) ? $clog2(buf_depth) : 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [flit_width-1:0]                   flit_in,
    input  logic [num_pls-1:0]                      flit_in_valid,
    input  logic [num_pls-1:0]                      pl_deq,
    output logic [num_pls-1:0][flit_width-1:0]      pl_head_data,
    output logic [num_pls-1:0]                      pl_head_valid,
    output logic [num_pls-1:0][counter_bits-1:0]    pl_occupancy,
    output logic [num_pls-1:0]                      credits_out,
    output logic                                    overflow_err,
    output logic                                    underflow_err,
    output logic                                    proto_err
);

    logic [flit_width-1:0]                mem_q [num_pls][buf_depth];
    logic [num_pls-1:0][ptr_bits-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [num_pls-1:0][counter_bits-1:0] occ_q, occ_d;
    logic [num_pls-1:0][flit_width-1:0]   head_q, head_d;
    logic [num_pls-1:0]                   valid_q, valid_d;
    logic [num_pls-1:0]                   credit_q, credit_d;
    logic                                 ovf_q, ovf_d, udf_q, udf_d, proto_q, proto_d;
    logic [num_pls-1:0]                   full_c, empty_c, enq_c, deq_c;
    logic                                 multi_c;

    // Modulo-buf_depth pointer increment; depth need not be a power of two.
    function automatic logic [ptr_bits-1:0] ptr_inc(input logic [ptr_bits-1:0] p);
        return (p == ptr_bits'(buf_depth - 1)) ? '0 : p + ptr_bits'(1);
    endfunction

    assign multi_c = (flit_in_valid & (flit_in_valid - num_pls'(1))) != '0;

    always_comb begin
        wr_d     = wr_q;
        rd_d     = rd_q;
        occ_d    = occ_q;
        head_d   = '0;
        valid_d  = '0;
        credit_d = '0;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        proto_d  = proto_q | multi_c;
        full_c   = '0;
        empty_c  = '0;
        enq_c    = '0;
        deq_c    = '0;
        for (int i = 0; i < int'(num_pls); i++) begin
            full_c[i]  = (occ_q[i] == counter_bits'(buf_depth));
            empty_c[i] = (occ_q[i] == '0);
            enq_c[i]   = flit_in_valid[i] & ~multi_c & ~full_c[i];
            deq_c[i]   = pl_deq[i] & ~empty_c[i];
            ovf_d      = ovf_d | (flit_in_valid[i] & ~multi_c & full_c[i]);
            udf_d      = udf_d | (pl_deq[i] & empty_c[i]);
            if (enq_c[i]) wr_d[i] = ptr_inc(wr_q[i]);
            if (deq_c[i]) rd_d[i] = ptr_inc(rd_q[i]);
            if (enq_c[i] && !deq_c[i]) occ_d[i] = occ_q[i] + counter_bits'(1);
            if (deq_c[i] && !enq_c[i]) occ_d[i] = occ_q[i] - counter_bits'(1);
            credit_d[i] = deq_c[i];
            valid_d[i]  = (occ_d[i] != '0);
            // The new head is the flit being written only when it lands at the next read slot.
            if (valid_d[i]) begin
                head_d[i] = (enq_c[i] && (wr_q[i] == rd_d[i])) ? flit_in : mem_q[i][rd_d[i]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q     <= '0;
            rd_q     <= '0;
            occ_q    <= '0;
            head_q   <= '0;
            valid_q  <= '0;
            credit_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            proto_q  <= 1'b0;
        end else begin
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            occ_q    <= occ_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
            credit_q <= credit_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            proto_q  <= proto_d;
        end
    end

    // Flit storage carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(num_pls); i++) begin
            if (enq_c[i]) mem_q[i][wr_q[i]] <= flit_in;
        end
    end

    assign pl_head_data  = head_q;
    assign pl_head_valid = valid_q;
    assign pl_occupancy  = occ_q;
    assign credits_out   = credit_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = udf_q;
    assign proto_err     = proto_q;

endmodule

// File: tb/tb_lag_pl_fc_in.sv
// Directed bench for lag_pl_fc_in: reset, single flit, wrap, simultaneous ops,
// overflow/underflow, protocol error and mid-operation reset.
module tb_lag_pl_fc_in;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       flit_in;
    logic [3:0]        flit_in_valid;
    logic [3:0]        pl_deq;
    logic [3:0][31:0]  pl_head_data;
    logic [3:0]        pl_head_valid;
    logic [3:0][2:0]   pl_occupancy;
    logic [3:0]        credits_out;
    logic              overflow_err, underflow_err, proto_err;

    int passed = 0;
    int total  = 0;

    lag_pl_fc_in dut (
        .clk(clk), .rst(rst), .flit_in(flit_in), .flit_in_valid(flit_in_valid),
        .pl_deq(pl_deq), .pl_head_data(pl_head_data), .pl_head_valid(pl_head_valid),
        .pl_occupancy(pl_occupancy), .credits_out(credits_out),
        .overflow_err(overflow_err), .underflow_err(underflow_err), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    // Advance one edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flit_in_valid = '0;
        pl_deq        = '0;
        flit_in       = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;
        total++; if (pl_head_valid !== 4'b0000) $display("FAIL reset_valid got=%b exp=0000", pl_head_valid); else passed++;
        total++; if (pl_occupancy !== 12'h000) $display("FAIL reset_occ got=%h exp=000", pl_occupancy); else passed++;
        total++; if (credits_out !== 4'b0000) $display("FAIL reset_credit got=%b exp=0000", credits_out); else passed++;
        total++; if ({overflow_err, underflow_err, proto_err} !== 3'b000)
            $display("FAIL reset_err got=%b exp=000", {overflow_err, underflow_err, proto_err}); else passed++;
        total++; if (pl_head_data !== 128'h0) $display("FAIL reset_head got=%h exp=0", pl_head_data); else passed++;
    endtask

    task automatic test_single_flit();
        flit_in = 32'hA5; flit_in_valid = 4'b0100;
        step();
        idle();
        total++; if (pl_head_valid !== 4'b0100) $display("FAIL single_valid got=%b exp=0100", pl_head_valid); else passed++;
        total++; if (pl_head_data[2] !== 32'hA5) $display("FAIL single_head got=%h exp=a5", pl_head_data[2]); else passed++;
        total++; if (pl_occupancy[2] !== 3'd1) $display("FAIL single_occ got=%0d exp=1", pl_occupancy[2]); else passed++;
        pl_deq = 4'b0100;
        step();
        idle();
        total++; if (credits_out !== 4'b0100) $display("FAIL single_credit got=%b exp=0100", credits_out); else passed++;
        total++; if (pl_occupancy[2] !== 3'd0) $display("FAIL single_occ_after got=%0d exp=0", pl_occupancy[2]); else passed++;
        total++; if (pl_head_data[2] !== 32'h0) $display("FAIL single_head_zero got=%h exp=0", pl_head_data[2]); else passed++;
        step();
        total++; if (credits_out !== 4'b0000) $display("FAIL single_credit_once got=%b exp=0000", credits_out); else passed++;
    endtask

    task automatic test_fill_wrap();
        int exp_head = 1;
        int credits  = 0;
        int bad      = 0;
        for (int k = 1; k <= 4; k++) begin
            flit_in = 32'(k); flit_in_valid = 4'b0001;
            step();
        end
        idle();
        total++; if (pl_occupancy[0] !== 3'd4) $display("FAIL wrap_full_occ got=%0d exp=4", pl_occupancy[0]); else passed++;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) begin
                if (pl_head_data[0] !== 32'(exp_head)) bad++;
                exp_head++;
                pl_deq = 4'b0001;
            end else begin
                flit_in = 32'(5 + k / 2); flit_in_valid = 4'b0001;
            end
            step();
            idle();
            credits += int'(credits_out[0]);
        end
        total++; if (pl_occupancy[0] !== 3'd4) $display("FAIL wrap_mid_occ got=%0d exp=4", pl_occupancy[0]); else passed++;
        for (int k = 0; k < 4; k++) begin
            if (pl_head_data[0] !== 32'(exp_head)) bad++;
            exp_head++;
            pl_deq = 4'b0001;
            step();
            idle();
            credits += int'(credits_out[0]);
        end
        step();
        credits += int'(credits_out[0]);
        total++; if (bad !== 0) $display("FAIL wrap_order got=%0d bad heads exp=0", bad); else passed++;
        total++; if (credits !== 7) $display("FAIL wrap_credits got=%0d exp=7", credits); else passed++;
        total++; if (pl_head_valid[0] !== 1'b0) $display("FAIL wrap_empty got=%b exp=0", pl_head_valid[0]); else passed++;
    endtask

    task automatic test_simultaneous();
        flit_in = 32'h11; flit_in_valid = 4'b0010; step();
        flit_in = 32'h12; flit_in_valid = 4'b0010; step();
        flit_in = 32'h13; flit_in_valid = 4'b0010; pl_deq = 4'b0010;
        step();
        idle();
        total++; if (pl_occupancy[1] !== 3'd2) $display("FAIL simul_occ got=%0d exp=2", pl_occupancy[1]); else passed++;
        total++; if (credits_out !== 4'b0010) $display("FAIL simul_credit got=%b exp=0010", credits_out); else passed++;
        total++; if (pl_head_data[1] !== 32'h12) $display("FAIL simul_head got=%h exp=12", pl_head_data[1]); else passed++;
        flit_in = 32'h20; flit_in_valid = 4'b0001; step();
        flit_in = 32'h30; flit_in_valid = 4'b1000; step();
        idle();
        pl_deq = 4'b1001;
        step();
        idle();
        total++; if (credits_out !== 4'b1001) $display("FAIL dual_credit got=%b exp=1001", credits_out); else passed++;
        total++; if (pl_head_valid !== 4'b0010) $display("FAIL dual_valid got=%b exp=0010", pl_head_valid); else passed++;
    endtask

    task automatic test_over_underflow();
        for (int k = 0; k < 4; k++) begin
            flit_in = 32'h41 + 32'(k); flit_in_valid = 4'b0001;
            step();
        end
        total++; if (overflow_err !== 1'b0) $display("FAIL ovf_early got=%b exp=0", overflow_err); else passed++;
        flit_in = 32'h45; flit_in_valid = 4'b0001; pl_deq = 4'b0001;
        step();
        idle();
        total++; if (overflow_err !== 1'b1) $display("FAIL ovf_flag got=%b exp=1", overflow_err); else passed++;
        total++; if (pl_occupancy[0] !== 3'd3) $display("FAIL ovf_occ got=%0d exp=3", pl_occupancy[0]); else passed++;
        total++; if (credits_out !== 4'b0001) $display("FAIL ovf_credit got=%b exp=0001", credits_out); else passed++;
        for (int k = 0; k < 3; k++) begin
            total++; if (pl_head_data[0] !== 32'h42 + 32'(k))
                $display("FAIL ovf_drain got=%h exp=%h", pl_head_data[0], 32'h42 + 32'(k)); else passed++;
            pl_deq = 4'b0001;
            step();
            idle();
        end
        total++; if (pl_head_valid[0] !== 1'b0) $display("FAIL ovf_dropped got=%b exp=0", pl_head_valid[0]); else passed++;
        step();
        total++; if (underflow_err !== 1'b0) $display("FAIL udf_early got=%b exp=0", underflow_err); else passed++;
        pl_deq = 4'b1000;
        step();
        idle();
        total++; if (credits_out !== 4'b0000) $display("FAIL udf_credit got=%b exp=0000", credits_out); else passed++;
        total++; if (underflow_err !== 1'b1) $display("FAIL udf_flag got=%b exp=1", underflow_err); else passed++;
        step();
        total++; if (overflow_err !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", overflow_err); else passed++;
    endtask

    task automatic test_proto_and_reset();
        flit_in = 32'h77; flit_in_valid = 4'b0011;
        step();
        idle();
        total++; if (proto_err !== 1'b1) $display("FAIL proto_flag got=%b exp=1", proto_err); else passed++;
        total++; if (pl_occupancy[0] !== 3'd0) $display("FAIL proto_occ0 got=%0d exp=0", pl_occupancy[0]); else passed++;
        total++; if (pl_occupancy[1] !== 3'd2) $display("FAIL proto_occ1 got=%0d exp=2", pl_occupancy[1]); else passed++;
        pl_deq = 4'b0010;
        step();
        total++; if (credits_out !== 4'b0010) $display("FAIL pre_rst_credit got=%b exp=0010", credits_out); else passed++;
        rst = 1'b1;
        flit_in = 32'h99; flit_in_valid = 4'b0100;
        step();
        rst = 1'b0;
        idle();
        total++; if (credits_out !== 4'b0000) $display("FAIL rst_credit got=%b exp=0000", credits_out); else passed++;
        total++; if (pl_head_valid !== 4'b0000) $display("FAIL rst_valid got=%b exp=0000", pl_head_valid); else passed++;
        total++; if (pl_occupancy !== 12'h000) $display("FAIL rst_occ got=%h exp=000", pl_occupancy); else passed++;
        total++; if (pl_head_data !== 128'h0) $display("FAIL rst_head got=%h exp=0", pl_head_data); else passed++;
        total++; if ({overflow_err, underflow_err, proto_err} !== 3'b000)
            $display("FAIL rst_err got=%b exp=000", {overflow_err, underflow_err, proto_err}); else passed++;
        step();
        total++; if (credits_out !== 4'b0000) $display("FAIL post_rst_credit got=%b exp=0000", credits_out); else passed++;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_single_flit();
        test_fill_wrap();
        test_simultaneous();
        test_over_underflow();
        test_proto_and_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
